itlb_miss_ctrl: RTL and testbench

//  Lookup/refill controller for the ITLB tag array. Accepts a fetch translation request and

---
 rtl/mms_pkg.sv | 32 +++
 rtl/itlb_hit_enc.sv | 25 ++
 rtl/itlb_miss_ctrl.sv | 112 +++++++++++
 tb/tb_itlb_miss_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mms_pkg.sv
// Shared memory-management types for the ITLB (and later DTLB) controllers.
`ifndef ASID_WD
`define ASID_WD 16
`endif

package mms_pkg;

    localparam int ASID_WD      = `ASID_WD;
    localparam int ITLB_ENTRIES = 8;

    typedef struct packed {
        logic [9:0] vpn1;
        logic [9:0] vpn0;
    } vpn_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_PTW_REQ  = 3'd2;
    localparam logic [2:0] ST_PTW_WAIT = 3'd3;
    localparam logic [2:0] ST_REFILL   = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_LOOKUP   = ST_LOOKUP,
        S_PTW_REQ  = ST_PTW_REQ,
        S_PTW_WAIT = ST_PTW_WAIT,
        S_REFILL   = ST_REFILL,
        S_DRAIN    = ST_DRAIN
    } itlb_state_e;

endpackage

// File: rtl/itlb_hit_enc.sv
// Lowest-index priority encoder over a TLB hit vector, with any/multi-hit flags.
module itlb_hit_enc
    import mms_pkg::*;
#(
    parameter  int ENTRIES = ITLB_ENTRIES,
    localparam int IDX_WD  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] hit_vec_i,
    output logic [IDX_WD-1:0]  idx_o,
    output logic               any_o,
    output logic               multi_o
);

    always_comb begin
        idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec_i[i]) idx_o = IDX_WD'(i);
        end
    end

    assign any_o   = |hit_vec_i;
    // clearing the lowest set bit leaves something only if two or more were set
    assign multi_o = |(hit_vec_i & (hit_vec_i - ENTRIES'(1)));

endmodule

// File: rtl/itlb_miss_ctrl.sv
// ITLB lookup/refill controller: broadcasts held request, walks on miss, refills round-robin.
//  state    | meaning
//  IDLE     | ready for an IFU request
//  LOOKUP   | tag entries compare held VPN/ASID
//  PTW_REQ  | walk request presented to PTW
//  PTW_WAIT | walk accepted, awaiting result
//  REFILL   | write result into victim entry, then replay lookup
//  DRAIN    | flushed with walk outstanding, discard its result
module itlb_miss_ctrl
    import mms_pkg::*;
#(
    parameter  int ENTRIES = ITLB_ENTRIES,
    localparam int IDX_WD  = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [19:0]        req_vpn_i,
    input  logic [ASID_WD-1:0] req_asid_i,
    output logic [19:0]        lkup_vpn_o,
    output logic [ASID_WD-1:0] lkup_asid_o,
    input  logic [ENTRIES-1:0] hit_vec_i,
    output logic               rsp_valid_o,
    output logic [IDX_WD-1:0]  rsp_idx_o,
    output logic               rsp_fault_o,
    output logic               multihit_o,
    output logic               ptw_req_valid_o,
    input  logic               ptw_req_ready_i,
    output logic [19:0]        ptw_req_vpn_o,
    input  logic               ptw_rsp_valid_i,
    input  logic               ptw_rsp_fault_i,
    input  logic               ptw_rsp_g_i,
    output logic [ENTRIES-1:0] entry_we_o,
    output logic               wr_g_o,
    input  logic               flush_i
);

    itlb_state_e        state_q, state_d;
    vpn_t               vpn_q;
    logic [ASID_WD-1:0] asid_q;
    logic [IDX_WD-1:0]  victim_q;
    logic               g_q;

    logic              hit_any, hit_multi;
    logic [IDX_WD-1:0] hit_idx;
    logic              accept, lookup_hit, walk_fault, walk_ok, refill_fire;

    itlb_hit_enc #(.ENTRIES(ENTRIES)) u_hit_enc (
        .hit_vec_i (hit_vec_i),
        .idx_o     (hit_idx),
        .any_o     (hit_any),
        .multi_o   (hit_multi)
    );

    assign accept      = req_valid_i & req_ready_o;
    assign lookup_hit  = (state_q == S_LOOKUP) & hit_any & ~flush_i;
    assign walk_fault  = (state_q == S_PTW_WAIT) & ptw_rsp_valid_i & ptw_rsp_fault_i & ~flush_i;
    assign walk_ok     = (state_q == S_PTW_WAIT) & ptw_rsp_valid_i & ~ptw_rsp_fault_i & ~flush_i;
    assign refill_fire = (state_q == S_REFILL) & ~flush_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_LOOKUP;
            S_LOOKUP:   state_d = (flush_i || hit_any) ? S_IDLE : S_PTW_REQ;
            S_PTW_REQ: begin
                // a ready seen alongside flush means the PTW already owns the walk
                if (flush_i)              state_d = ptw_req_ready_i ? S_DRAIN : S_IDLE;
                else if (ptw_req_ready_i) state_d = S_PTW_WAIT;
            end
            S_PTW_WAIT: begin
                if (flush_i)              state_d = ptw_rsp_valid_i ? S_IDLE : S_DRAIN;
                else if (ptw_rsp_valid_i) state_d = ptw_rsp_fault_i ? S_IDLE : S_REFILL;
            end
            S_REFILL:   state_d = flush_i ? S_IDLE : S_LOOKUP;
            S_DRAIN:    if (ptw_rsp_valid_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            vpn_q    <= '0;
            asid_q   <= '0;
            victim_q <= '0;
            g_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                vpn_q  <= req_vpn_i;
                asid_q <= req_asid_i;
            end
            if (walk_ok)     g_q      <= ptw_rsp_g_i;
            if (refill_fire) victim_q <= victim_q + 1'b1;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE) & ~flush_i;
    assign lkup_vpn_o      = vpn_q;
    assign lkup_asid_o     = asid_q;
    assign ptw_req_vpn_o   = vpn_q;
    assign ptw_req_valid_o = (state_q == S_PTW_REQ);
    assign rsp_valid_o     = lookup_hit | walk_fault;
    assign rsp_idx_o       = lookup_hit ? hit_idx : '0;
    assign rsp_fault_o     = walk_fault;
    assign multihit_o      = lookup_hit & hit_multi;
    assign entry_we_o      = refill_fire ? (ENTRIES'(1) << victim_q) : '0;
    assign wr_g_o          = refill_fire & g_q;

endmodule

// File: tb/tb_itlb_miss_ctrl.sv
// Bench for itlb_miss_ctrl: emulated tag array and PTW, transaction-level reference model.
module tb_itlb_miss_ctrl;
    import mms_pkg::*;

    localparam int ENTRIES = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready_o;
    logic [19:0]        req_vpn;
    logic [ASID_WD-1:0] req_asid;
    logic [19:0]        lkup_vpn_o;
    logic [ASID_WD-1:0] lkup_asid_o;
    logic [ENTRIES-1:0] hit_vec;
    logic               rsp_valid_o;
    logic [2:0]         rsp_idx_o;
    logic               rsp_fault_o;
    logic               multihit_o;
    logic               ptw_req_valid_o;
    logic               ptw_ready;
    logic [19:0]        ptw_req_vpn_o;
    logic               ptw_rsp_valid;
    logic               ptw_rsp_fault;
    logic               ptw_rsp_g;
    logic [ENTRIES-1:0] entry_we_o;
    logic               wr_g_o;
    logic               flush;

    logic               tv    [ENTRIES];
    logic [19:0]        tvpn  [ENTRIES];
    logic [ASID_WD-1:0] tasid [ENTRIES];
    logic               tg    [ENTRIES];
    logic               force_en;
    logic [ENTRIES-1:0] force_val;

    int n_chk = 0;
    int n_err = 0;
    int model_victim = 0;

    always #5 clk = ~clk;

    itlb_miss_ctrl #(.ENTRIES(ENTRIES)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_vpn_i       (req_vpn),
        .req_asid_i      (req_asid),
        .lkup_vpn_o      (lkup_vpn_o),
        .lkup_asid_o     (lkup_asid_o),
        .hit_vec_i       (hit_vec),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_idx_o       (rsp_idx_o),
        .rsp_fault_o     (rsp_fault_o),
        .multihit_o      (multihit_o),
        .ptw_req_valid_o (ptw_req_valid_o),
        .ptw_req_ready_i (ptw_ready),
        .ptw_req_vpn_o   (ptw_req_vpn_o),
        .ptw_rsp_valid_i (ptw_rsp_valid),
        .ptw_rsp_fault_i (ptw_rsp_fault),
        .ptw_rsp_g_i     (ptw_rsp_g),
        .entry_we_o      (entry_we_o),
        .wr_g_o          (wr_g_o),
        .flush_i         (flush)
    );

    // tag entries: valid, VPN match, and ASID match unless global
    always_comb begin
        hit_vec = '0;
        if (force_en) hit_vec = force_val;
        else begin
            for (int i = 0; i < ENTRIES; i++)
                if (tv[i] && tvpn[i] == lkup_vpn_o && (tg[i] || tasid[i] == lkup_asid_o))
                    hit_vec[i] = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [ENTRIES-1:0] we;
        logic [19:0]        v;
        logic [ASID_WD-1:0] a;
        logic               g;
        logic               fl;
        we = entry_we_o; v = lkup_vpn_o; a = lkup_asid_o; g = wr_g_o; fl = flush;
        @(posedge clk);
        for (int i = 0; i < ENTRIES; i++) begin
            if (we[i]) begin
                tv[i] = 1'b1; tvpn[i] = v; tasid[i] = a; tg[i] = g;
            end
            if (fl) tv[i] = 1'b0;
        end
        #2;
    endtask

    task automatic clear_tags();
        for (int i = 0; i < ENTRIES; i++) begin
            tv[i] = 1'b0; tvpn[i] = '0; tasid[i] = '0; tg[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_victim = 0;
    endtask

    task automatic check_reset_outs(input string pfx);
        chk({pfx, "_ready"},   32'(req_ready_o), 1);
        chk({pfx, "_lvpn"},    32'(lkup_vpn_o), 0);
        chk({pfx, "_lasid"},   32'(lkup_asid_o), 0);
        chk({pfx, "_rsp"},     32'({rsp_valid_o, rsp_fault_o, multihit_o}), 0);
        chk({pfx, "_idx"},     32'(rsp_idx_o), 0);
        chk({pfx, "_ptw"},     32'(ptw_req_valid_o), 0);
        chk({pfx, "_ptwvpn"},  32'(ptw_req_vpn_o), 0);
        chk({pfx, "_we"},      32'(entry_we_o), 0);
        chk({pfx, "_wrg"},     32'(wr_g_o), 0);
    endtask

    task automatic model_hits(input logic [19:0] vpn, input logic [ASID_WD-1:0] asid,
                              output int n, output int low);
        n = 0; low = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (tv[i] && tvpn[i] == vpn && (tg[i] || tasid[i] == asid)) begin
                if (n == 0) low = i;
                n++;
            end
    endtask

    task automatic do_req(input logic [19:0] vpn, input logic [ASID_WD-1:0] asid,
                          input int rdy_dly, input int lat, input bit fault, input bit g);
        int n, low, slot;
        model_hits(vpn, asid, n, low);
        chk("idle_ready", 32'(req_ready_o), 1);
        req_valid = 1'b1; req_vpn = vpn; req_asid = asid;
        tick();
        req_valid = 1'b0; req_vpn = '0; req_asid = '0;
        #1;
        chk("lkup_vpn", 32'(lkup_vpn_o), 32'(vpn));
        chk("lkup_asid", 32'(lkup_asid_o), 32'(asid));
        if (n > 0) begin
            chk("hit_rsp", 32'(rsp_valid_o), 1);
            chk("hit_idx", 32'(rsp_idx_o), 32'(low));
            chk("hit_multi", 32'(multihit_o), 32'(n > 1));
            chk("hit_fault", 32'(rsp_fault_o), 0);
            tick();
            return;
        end
        chk("miss_norsp", 32'(rsp_valid_o), 0);
        tick();
        for (int d = 0; d <= rdy_dly; d++) begin
            ptw_ready = (d == rdy_dly);
            #1;
            chk("ptw_valid", 32'(ptw_req_valid_o), 1);
            chk("ptw_vpn", 32'(ptw_req_vpn_o), 32'(vpn));
            tick();
        end
        ptw_ready = 1'b0;
        for (int c = 0; c < lat; c++) begin
            chk("wait_quiet", 32'({ptw_req_valid_o, rsp_valid_o, |entry_we_o}), 0);
            tick();
        end
        ptw_rsp_valid = 1'b1; ptw_rsp_fault = fault; ptw_rsp_g = g;
        #1;
        chk("walk_rsp", 32'(rsp_valid_o), 32'(fault));
        chk("walk_fault", 32'(rsp_fault_o), 32'(fault));
        tick();
        ptw_rsp_valid = 1'b0; ptw_rsp_fault = 1'b0; ptw_rsp_g = 1'b0;
        #1;
        if (fault) begin
            chk("fault_nowrite", 32'(entry_we_o), 0);
            chk("fault_ready", 32'(req_ready_o), 1);
            return;
        end
        slot = model_victim;
        model_victim = (model_victim + 1) % ENTRIES;
        chk("refill_we", 32'(entry_we_o), 32'(1) << slot);
        chk("refill_g", 32'(wr_g_o), 32'(g));
        chk("refill_norsp", 32'(rsp_valid_o), 0);
        tick();
        chk("replay_rsp", 32'(rsp_valid_o), 1);
        chk("replay_idx", 32'(rsp_idx_o), 32'(slot));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_vpn = '0; req_asid = '0;
        ptw_ready = 1'b0; ptw_rsp_valid = 1'b0; ptw_rsp_fault = 1'b0; ptw_rsp_g = 1'b0;
        flush = 1'b0; force_en = 1'b0; force_val = '0;
        clear_tags();
        do_reset();
        check_reset_outs("rst");

        // preloaded hit
        tv[3] = 1'b1; tvpn[3] = 20'h004FF; tasid[3] = 16'd2; tg[3] = 1'b0;
        do_req(20'h004FF, 16'd2, 0, 0, 1'b0, 1'b0);

        // miss/refill into entries 0 then 1, then a fault that writes nothing
        clear_tags();
        do_req(20'h001FF, 16'd1, 2, 5, 1'b0, 1'b1);
        do_req(20'h00200, 16'd1, 0, 1, 1'b0, 1'b0);
        do_req(20'h00300, 16'd1, 1, 2, 1'b1, 1'b0);

        // flush while walk outstanding; a second flush in DRAIN is ignored
        req_valid = 1'b1; req_vpn = 20'h00AAA; req_asid = 16'd1;
        tick();
        req_valid = 1'b0;
        tick();
        ptw_ready = 1'b1; #1;
        tick();
        ptw_ready = 1'b0;
        flush = 1'b1; #1;
        chk("fl_wait_norsp", 32'(rsp_valid_o), 0);
        tick();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1); #1;
            chk("drain_ready", 32'(req_ready_o), 0);
            chk("drain_ptw", 32'(ptw_req_valid_o), 0);
            tick();
            flush = 1'b0;
        end
        ptw_rsp_valid = 1'b1; #1;
        chk("drain_norsp", 32'(rsp_valid_o), 0);
        chk("drain_nowe", 32'(entry_we_o), 0);
        chk("drain_ready_rsp", 32'(req_ready_o), 0);
        tick();
        ptw_rsp_valid = 1'b0; #1;
        chk("drain_done_ready", 32'(req_ready_o), 1);
        chk("drain_done_we", 32'(entry_we_o), 0);

        // victim pointer survives the flush
        do_req(20'h00400, 16'd1, 0, 0, 1'b0, 1'b0);

        // flush in PTW_REQ without ready drops the walk
        req_valid = 1'b1; req_vpn = 20'h00BBB; req_asid = 16'd1;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1; #1;
        tick();
        flush = 1'b0; #1;
        chk("fl_req_ready", 32'(req_ready_o), 1);
        chk("fl_req_ptw", 32'(ptw_req_valid_o), 0);

        // forced multi-hit
        force_en = 1'b1; force_val = 8'h0A;
        req_valid = 1'b1; req_vpn = 20'h00CCC; req_asid = 16'd3;
        tick();
        req_valid = 1'b0; #1;
        chk("mh_rsp", 32'(rsp_valid_o), 1);
        chk("mh_idx", 32'(rsp_idx_o), 1);
        chk("mh_flag", 32'(multihit_o), 1);
        tick();
        chk("mh_flag_clear", 32'(multihit_o), 0);
        force_en = 1'b0;

        // reset while requesting a walk
        clear_tags();
        req_valid = 1'b1; req_vpn = 20'h00DDD; req_asid = 16'd5;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_ptw", 32'(ptw_req_valid_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_victim = 0;
        check_reset_outs("midrst");

        // round-robin wrap: ninth refill lands in entry 0 again
        do_reset();
        clear_tags();
        for (int i = 0; i < 9; i++)
            do_req(20'h10000 + 20'(i), 16'd1, 0, 1, 1'b0, 1'b0);
        chk("wrap_victim", 32'(model_victim), 1);

        // randomized traffic over a small VPN pool so hits, misses and globals mix
        do_reset();
        clear_tags();
        for (int t = 0; t < 60; t++) begin
            do_req(20'h30000 + 20'($urandom_range(0, 11)),
                   ASID_WD'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)),
                   ($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
